// File: rtl/mc10_vram_pkg.sv
// Shared types and constants for the MC-10 video RAM arbiter.
package mc10_vram_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 13;
    localparam int unsigned AS_BIT         = 7;
    localparam int unsigned INV_BIT        = 6;

    typedef enum logic [1:0] {
        StIdle,
        StVdgRd,
        StCpuRd,
        StCpuWr
    } vram_state_e;

endpackage

// File: rtl/mc10_vram_lat_pipe.sv
// RD_LAT-deep valid/tag shift register; o_ret_vld marks the cycle read data returns from RAM.
module mc10_vram_lat_pipe #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_push,
    input  logic i_is_vdg,
    output logic o_ret_vld,
    output logic o_ret_vdg
);

    logic [RD_LAT-1:0] r_vld;
    logic [RD_LAT-1:0] r_vdg;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_vld <= '0;
            r_vdg <= '0;
        end else begin
            r_vld[0] <= i_push;
            r_vdg[0] <= i_is_vdg;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_vdg[i] <= r_vdg[i-1];
            end
        end
    end

    assign o_ret_vld = r_vld[RD_LAT-1];
    assign o_ret_vdg = r_vdg[RD_LAT-1];

endmodule

// File: rtl/mc10_vram_arbiter.sv
// Single-port video RAM arbiter between the CPU bus and the 6847 VDG fetch path.
// Define MC10_VRAM_STARVE_GUARD_EN to let a starved CPU win one arbitration over the VDG.
module mc10_vram_arbiter
    import mc10_vram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned RD_LAT = 1
`ifdef MC10_VRAM_STARVE_GUARD_EN
    ,
    parameter int unsigned STARVE_MAX = 8
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_ena,
    input  logic [ADDR_W-1:0] vdg_addr,
    output logic [7:0]        vdg_dd,
    output logic              vdg_an_s,
    output logic              vdg_inv,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    vram_state_e       r_state, w_state_nxt;
    logic              r_vdg_pend;
    logic [ADDR_W-1:0] r_vaddr;
    logic              r_ack, r_ack_q;
    logic [7:0]        r_rdata, r_dd;
    logic              r_an_s, r_inv;

    logic w_cpu_ok, w_vdg_want, w_cpu_first, w_grant_vdg;
    logic w_push, w_push_vdg, w_ret_vld, w_ret_vdg, w_ack_set;

    // A held request must not be re-served in the ack cycle or the one after it.
    assign w_cpu_ok   = reset_n && cpu_req && !r_ack && !r_ack_q;
    assign w_vdg_want = reset_n && (r_vdg_pend || clk_ena);

`ifdef MC10_VRAM_STARVE_GUARD_EN
    localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
    logic [StarveW-1:0] r_starve;

    always_ff @(posedge clk) begin
        if (!reset_n || r_ack) begin
            r_starve <= '0;
        end else if (cpu_req && (r_starve != StarveW'(STARVE_MAX))) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    assign w_cpu_first = (r_starve == StarveW'(STARVE_MAX));
`else
    assign w_cpu_first = 1'b0;
`endif

    mc10_vram_lat_pipe #(
        .RD_LAT(RD_LAT)
    ) u_lat_pipe (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .i_push    (w_push),
        .i_is_vdg  (w_push_vdg),
        .o_ret_vld (w_ret_vld),
        .o_ret_vdg (w_ret_vdg)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant_vdg = 1'b0;
        w_push      = 1'b0;
        w_push_vdg  = 1'b0;
        ram_addr    = '0;
        ram_we      = 1'b0;
        ram_wdata   = '0;
        unique case (r_state)
            StIdle: begin
                if (w_vdg_want && !(w_cpu_first && w_cpu_ok)) begin
                    // A same-cycle pulse carries the newest address; the latched one is stale.
                    ram_addr    = clk_ena ? vdg_addr : r_vaddr;
                    w_grant_vdg = 1'b1;
                    w_push      = 1'b1;
                    w_push_vdg  = 1'b1;
                    w_state_nxt = StVdgRd;
                end else if (w_cpu_ok && cpu_we) begin
                    ram_addr    = cpu_addr;
                    ram_we      = 1'b1;
                    ram_wdata   = cpu_wdata;
                    w_state_nxt = StCpuWr;
                end else if (w_cpu_ok) begin
                    ram_addr    = cpu_addr;
                    w_push      = 1'b1;
                    w_state_nxt = StCpuRd;
                end
            end
            StVdgRd: if (w_ret_vld) w_state_nxt = StIdle;
            StCpuRd: if (w_ret_vld) w_state_nxt = StIdle;
            StCpuWr: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
        w_ack_set = ram_we || (w_ret_vld && !w_ret_vdg);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= StIdle;
            r_vdg_pend <= 1'b0;
            r_vaddr    <= '0;
            r_ack      <= 1'b0;
            r_ack_q    <= 1'b0;
            r_rdata    <= '0;
            r_dd       <= '0;
            r_an_s     <= 1'b0;
            r_inv      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= w_ack_set;
            r_ack_q <= r_ack;
            if (w_grant_vdg) begin
                r_vdg_pend <= 1'b0;
            end else if (clk_ena) begin
                r_vdg_pend <= 1'b1;
            end
            if (clk_ena) begin
                r_vaddr <= vdg_addr;
            end
            if (w_ret_vld && w_ret_vdg) begin
                r_dd   <= ram_rdata;
                r_an_s <= ram_rdata[AS_BIT];
                r_inv  <= ram_rdata[INV_BIT];
            end
            if (w_ret_vld && !w_ret_vdg) begin
                r_rdata <= ram_rdata;
            end
        end
    end

    assign cpu_ack   = r_ack;
    assign cpu_rdata = r_rdata;
    assign vdg_dd    = r_dd;
    assign vdg_an_s  = r_an_s;
    assign vdg_inv   = r_inv;

endmodule

// File: tb/tb_mc10_vram_arbiter.sv
// Scoreboard bench for mc10_vram_arbiter with a behavioural synchronous-read RAM (RD_LAT=1).
module tb_mc10_vram_arbiter;

    localparam int unsigned AW  = 13;
    localparam int unsigned LAT = 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clk_ena = 1'b0;
    logic [AW-1:0] vdg_addr = '0;
    logic [7:0]    vdg_dd;
    logic          vdg_an_s, vdg_inv;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_wdata = '0;
    logic [7:0]    cpu_rdata;
    logic          cpu_ack;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;

    always #5 clk = ~clk;

    mc10_vram_arbiter #(
        .ADDR_W(AW),
        .RD_LAT(LAT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_ena   (clk_ena),
        .vdg_addr  (vdg_addr),
        .vdg_dd    (vdg_dd),
        .vdg_an_s  (vdg_an_s),
        .vdg_inv   (vdg_inv),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // RAM macro with a backdoor preload port
    logic [7:0]    mem     [0:8191];
    logic [7:0]    rd_pipe [LAT];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [7:0]    bd_data = '0;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else if (bd_we) mem[bd_addr] <= bd_data;
        rd_pipe[0] <= mem[ram_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[LAT-1];

    typedef struct packed {
        logic       rd;
        logic [7:0] data;
    } cpu_exp_t;

    logic [7:0] sh_mem [0:8191];
    cpu_exp_t   q_cpu [$];
    logic [9:0] q_vdg [$];
    logic [9:0] cur_vdg = '0;
    cpu_exp_t   mon_e;
    int n_cmp = 0, n_err = 0;
    int n_ack = 0, n_we = 0, exp_ack = 0, exp_we = 0;
    logic [AW-1:0] st_addr [5];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cpu_ack) begin
            n_ack++;
            if (q_cpu.size() == 0) begin
                check_eq("ack_unexpected", 64'(cpu_ack), 64'(0));
            end else begin
                mon_e = q_cpu.pop_front();
                if (mon_e.rd) check_eq("cpu_rdata", 64'(cpu_rdata), 64'(mon_e.data));
            end
        end
        if (ram_we) n_we++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        sh_mem[a] = d;
        tick();
        bd_we = 1'b0;
    endtask

    function automatic logic [9:0] vdg_exp(input logic [AW-1:0] a);
        logic [7:0] d;
        d = sh_mem[a];
        return {d, d[7], d[6]};
    endfunction

    task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                              input int exp_lat, input int hold, input bit chk_grant);
        cpu_exp_t e;
        int n;
        e.rd   = !we;
        e.data = we ? 8'h00 : sh_mem[a];
        q_cpu.push_back(e);
        exp_ack++;
        if (we) begin
            sh_mem[a] = d;
            exp_we++;
        end
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        n = 0;
        @(negedge clk);
        if (chk_grant)
            check_eq("grant_bus", 64'({ram_we, ram_addr, we ? ram_wdata : 8'h00}),
                     64'({we, a, we ? d : 8'h00}));
        while (!cpu_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("ack_latency", 64'(n), 64'(exp_lat));
        for (int i = 0; i <= hold; i++) tick();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    // Pulse clk_ena at a; display must hold its old value until lat cycles later.
    task automatic vdg_fetch(input logic [AW-1:0] a, input int lat);
        logic [9:0] exp;
        exp = vdg_exp(a);
        q_vdg.push_back(exp);
        clk_ena  = 1'b1;
        vdg_addr = a;
        @(negedge clk);
        check_eq("vdg_no_ram_we", 64'(ram_we), 64'(0));
        tick();
        clk_ena = 1'b0;
        repeat (lat - 2) tick();
        @(negedge clk);
        check_eq("vdg_hold_old", 64'({vdg_dd, vdg_an_s, vdg_inv}), 64'(cur_vdg));
        @(negedge clk);
        cur_vdg = q_vdg.pop_front();
        check_eq("vdg_update", 64'({vdg_dd, vdg_an_s, vdg_inv}), 64'(cur_vdg));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        st_addr[0] = 13'h0123;
        st_addr[1] = 13'h0002;
        st_addr[2] = 13'h0001;
        st_addr[3] = 13'h0200;
        st_addr[4] = 13'h0123;
        tick();
        preload(13'h0123, 8'hC5);
        preload(13'h0010, 8'h3C);
        preload(13'h0001, 8'h11);
        preload(13'h0002, 8'h22);
        preload(13'h0200, 8'h45);
        @(negedge clk);
        check_eq("reset_outputs", 64'({vdg_dd, vdg_an_s, vdg_inv, cpu_rdata, cpu_ack,
                                       ram_addr, ram_we, ram_wdata}), 64'(0));
        tick();
        reset_n = 1'b1;
        repeat (2) tick();

        // Reset lands while the CPU read is in flight: no ack, everything cleared
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 13'h0010;
        tick();
        reset_n = 1'b0;
        cpu_req = 1'b0;
        tick();
        @(negedge clk);
        check_eq("rst_mid_rd_outputs", 64'({vdg_dd, vdg_an_s, vdg_inv, cpu_rdata, cpu_ack,
                                            ram_addr, ram_we, ram_wdata}), 64'(0));
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_rd_no_ack", 64'(cpu_ack), 64'(0));
        tick();

        vdg_fetch(13'h0123, 2);

        tick();
        cpu_access(1'b1, 13'h1000, 8'h5A, 1, 1, 1'b1);
        tick();
        cpu_access(1'b0, 13'h1000, 8'h00, 2, 1, 1'b1);
        repeat (2) tick();
        @(negedge clk);
        check_eq("rdata_held", 64'(cpu_rdata), 64'(sh_mem[13'h1000]));
        repeat (2) tick();

        // Same-cycle collision: VDG first, CPU read pushed back two cycles
        fork
            cpu_access(1'b0, 13'h0010, 8'h00, 4, 0, 1'b0);
            vdg_fetch(13'h0200, 2);
        join
        repeat (3) tick();

        // Pulse during CPU_RD stays pending and is served from the latched address
        fork
            cpu_access(1'b0, 13'h0010, 8'h00, 2, 0, 1'b1);
            begin
                tick();
                vdg_fetch(13'h0001, 3);
            end
        join
        repeat (3) tick();

        // Overrun: two back-to-back pulses, only the newer address is fetched
        fork
            cpu_access(1'b0, 13'h1000, 8'h00, 2, 0, 1'b1);
            begin
                tick();
                clk_ena  = 1'b1;
                vdg_addr = 13'h0001;
                tick();
                vdg_fetch(13'h0002, 2);
            end
        join
        repeat (3) tick();
        @(negedge clk);
        check_eq("overrun_no_refetch", 64'({vdg_dd, vdg_an_s, vdg_inv}), 64'(cur_vdg));
        tick();

        // Periodic VDG traffic with a continuously requesting CPU
        fork
            cpu_access(1'b0, 13'h0010, 8'h00, 4, 0, 1'b0);
            for (int i = 0; i < 5; i++) begin
                clk_ena  = 1'b1;
                vdg_addr = st_addr[i];
                tick();
                clk_ena = 1'b0;
                repeat (3) tick();
            end
        join
        repeat (2) tick();
        @(negedge clk);
        cur_vdg = vdg_exp(st_addr[4]);
        check_eq("periodic_vdg_last", 64'({vdg_dd, vdg_an_s, vdg_inv}), 64'(cur_vdg));
        repeat (4) tick();

        check_eq("cpu_queue_drained", 64'(q_cpu.size()), 64'(0));
        check_eq("vdg_queue_drained", 64'(q_vdg.size()), 64'(0));
        check_eq("ack_count", 64'(n_ack), 64'(exp_ack));
        check_eq("ram_we_count", 64'(n_we), 64'(exp_we));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
